// File: rtl/mul_16_seq.sv
// mul_16_seq: sequential 16x16 shift-and-add multiplier, product = (a*b) mod 2^16.
// Revision: 1.0
`default_nettype none

module mul_16_seq #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [15:0] acc, mcand, mplier, sum;
  logic [4:0]  count;

  // Single shared adder; its carry-out is intentionally not kept.
  add_16 u_add (
    .a   (acc),
    .b   (mcand),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN: begin
        // Exit test uses the pre-shift mplier, so bit 1 upward is what remains.
        if (count == 5'd15 || (EARLY_EXIT && mplier[15:1] == 15'd0))
          state_nx = DONE;
      end
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 16'd0;
      mcand  <= 16'd0;
      mplier <= 16'd0;
      count  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= 16'd0;
            mcand  <= a;
            mplier <= b;
            count  <= 5'd0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= sum;
          mcand  <= {mcand[14:0], 1'b0};
          mplier <= {1'b0, mplier[15:1]};
          count  <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign product   = acc;

endmodule

// 16-bit wrapping adder used as the multiplier's accumulation datapath.
module add_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

`default_nettype wire
